seq_burst_ctrl: RTL and testbench
=================================

Name: seq_burst_ctrl

Overview:
- Burst scheduler for the serial test-pattern generators in the encode datapath.
- Two generator instances are attached: gen0 (repeating 1,0,1 pattern) and gen1 (repeating 1,0,1,0 pattern).
- Accepts burst commands (pattern select, bit count) over a valid/ready handshake and enables exactly one generator for exactly the commanded number of bits.
- Re-times the generator's serial bit onto a framed output stream, then enforces an idle gap between bursts and reports done, bit count and timeout.

Parameters:
LEN_W, 16, width of the burst length and bit counter; max burst length is 2^LEN_W-1.
GAP_CYCLES, 4, idle cycles after each burst before the next command is accepted (legal range 1..255).
TIMEOUT, 4, consecutive missing generator-valid cycles that abort a burst (legal range 2..15).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  burst command present.
cmd_ready  output  1  controller can accept a command; high only in IDLE.
cmd_pattern  input  1  0 = use gen0, 1 = use gen1.
cmd_len  input  LEN_W  number of bits in the burst; 0 is legal.
gen0_ena  output  1  enable to gen0.
gen0_data  input  1  gen0 serial bit.
gen0_valid  input  1  gen0 bit valid.
gen1_ena  output  1  enable to gen1.
gen1_data  input  1  gen1 serial bit.
gen1_valid  input  1  gen1 bit valid.
ser_data  output  1  framed serial bit (registered).
ser_valid  output  1  ser_data valid.
ser_sof  output  1  first bit of the burst.
ser_eof  output  1  last bit of the burst.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at burst end.
bit_cnt  output  LEN_W  bits emitted in the current or last burst.
err_timeout  output  1  sticky; the last burst was aborted by timeout.

Behaviour:
- Reset: all outputs registered.
  - Values 0: gen*_ena, ser_*, busy, done, bit_cnt, err_timeout, cmd_ready.
  - State becomes IDLE.
  - cmd_ready rises the first cycle after rst is low.
- Reset mid-burst: same as above at the next edge. The burst is dropped with no eof and no done.
  - Because the generators restart their pattern when ena falls, the next burst always starts from the pattern's first bit (1).
- States: IDLE, RUN, DRAIN, GAP.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready: latch pattern and len; clear bit_cnt and err_timeout.
  - len==0 → GAP, with done pulsed in the first GAP cycle; no ena, no ser_valid.
  - len>0 → RUN.
- RUN:
  - Selected gen*_ena=1 for exactly len consecutive cycles, starting the cycle after acceptance.
  - Non-selected ena stays 0.
  - After len ena cycles → DRAIN.
- Bit forwarding (RUN and DRAIN):
  - Each cycle with the selected gen_valid=1 and bits received < len registers the gen_data into ser_data with ser_valid=1 on the next cycle, and increments bit_cnt.
  - Latency: first ser_valid occurs 2 cycles after the first ena cycle.
  - The non-selected generator's valid/data are ignored.
  - The selected data is ignored when its valid=0.
- Framing:
  - ser_sof is set on the 1st forwarded bit; ser_eof on the len-th.
  - len=1: sof and eof in the same cycle.
- DRAIN: when the len-th bit is forwarded → GAP; done pulses in the cycle after ser_eof.
- Timeout:
  - In RUN (excluding its first cycle) and in DRAIN, count consecutive cycles with the selected gen_valid=0.
  - On reaching TIMEOUT:
    - Drop ena.
    - Set err_timeout.
    - Emit no eof; bit_cnt holds the partial count.
    - Pulse done next cycle.
    - Go to GAP.
- GAP:
  - Lasts exactly GAP_CYCLES cycles; done is high only in the first of them.
  - cmd_ready=0, busy=1.
  - Then → IDLE.
- bit_cnt holds after done until the next acceptance.
- Commands presented while busy are not accepted and must be held by upstream. With cmd_valid held high, the next accept occurs on the first IDLE cycle.

Test Plan:
- Pattern 0, len=7, accept at edge T:
  - gen0_ena high cycles T+1..T+7.
  - ser_data 1,0,1,1,0,1,1 on T+3..T+9; sof@T+3, eof@T+9.
  - done@T+10, bit_cnt=7; cmd_ready=1 at T+10+GAP_CYCLES.
- Pattern 1, len=6 → ser_data 1,0,1,0,1,0; gen0_ena never high; second command held valid is accepted exactly GAP_CYCLES cycles after done.
- len=0 → no ena, no ser_valid, done one cycle after acceptance, bit_cnt=0, cmd_ready returns after GAP_CYCLES.
- len=1, pattern 0 → single ser_valid with data 1, sof=eof=1 in the same cycle, then done.
- gen0_valid forced low, len=5 → err_timeout=1 after TIMEOUT missing cycles, no eof, bit_cnt=0, done pulse; next accepted command clears err_timeout.
- rst asserted in the 3rd RUN cycle of a len=10 burst → next edge: ena, ser_*, busy, done all 0 and state IDLE; a new len=3 pattern-0 burst outputs 1,0,1.

Source files
------------

// File: rtl/seq_burst_ctrl.sv
// Burst scheduler for two serial pattern generators: accepts burst commands,
// gates exactly one generator, re-times its bits onto a framed stream, then idles.
module seq_burst_ctrl #(
  parameter int LEN_W      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_pattern,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             gen0_ena,
  input  logic             gen0_data,
  input  logic             gen0_valid,
  output logic             gen1_ena,
  input  logic             gen1_data,
  input  logic             gen1_valid,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_sof,
  output logic             ser_eof,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_cnt,
  output logic             err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic             pattern_reg, pattern_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] ena_cnt_reg, ena_cnt_next;
  logic [LEN_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0]       miss_reg, miss_next;
  logic [7:0]       gap_reg, gap_next;
  logic             err_reg, err_next;
  logic             done_reg, done_next;
  logic             cmd_ready_reg, busy_reg;
  logic             ser_data_reg, ser_valid_reg, ser_sof_reg, ser_eof_reg;

  logic [1:0] gen_valid_vec, gen_data_vec, ena_vec;
  logic       sel_valid, sel_data;
  logic       accept, active, fwd, count_en, timeout_hit;

  assign gen_valid_vec = {gen1_valid, gen0_valid};
  assign gen_data_vec  = {gen1_data, gen0_data};
  assign sel_valid     = gen_valid_vec[pattern_reg];
  assign sel_data      = gen_data_vec[pattern_reg];

  assign accept   = (state_reg == S_IDLE) && cmd_valid && cmd_ready_reg;
  assign active   = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign fwd      = active && sel_valid && (bit_cnt_reg < len_reg);
  // The generator output lags its enable by a cycle, so the first RUN cycle never counts as a miss.
  assign count_en = ((state_reg == S_RUN) && (ena_cnt_reg != '0)) || (state_reg == S_DRAIN);
  assign timeout_hit = count_en && !sel_valid && (miss_reg == 4'(TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    len_next     = len_reg;
    ena_cnt_next = ena_cnt_reg;
    bit_cnt_next = fwd ? bit_cnt_reg + 1'b1 : bit_cnt_reg;
    miss_next    = (count_en && !sel_valid) ? miss_reg + 1'b1 : 4'd0;
    gap_next     = gap_reg;
    err_next     = err_reg;
    done_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          pattern_next = cmd_pattern;
          len_next     = cmd_len;
          ena_cnt_next = '0;
          bit_cnt_next = '0;
          miss_next    = 4'd0;
          err_next     = 1'b0;
          if (cmd_len == '0) begin
            state_next = S_GAP;
            gap_next   = 8'(GAP_CYCLES - 1);
            done_next  = 1'b1;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        ena_cnt_next = ena_cnt_reg + 1'b1;
        if (timeout_hit) begin
          state_next = S_GAP;
          gap_next   = 8'(GAP_CYCLES - 1);
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else if (ena_cnt_reg == len_reg - 1'b1) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // bit_cnt reaches len in the same cycle the eof bit is on the output.
        if (bit_cnt_reg == len_reg) begin
          state_next = S_GAP;
          gap_next   = 8'(GAP_CYCLES - 1);
          done_next  = 1'b1;
        end else if (timeout_hit) begin
          state_next = S_GAP;
          gap_next   = 8'(GAP_CYCLES - 1);
          done_next  = 1'b1;
          err_next   = 1'b1;
        end
      end
      default: begin
        if (gap_reg == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pattern_reg   <= 1'b0;
      len_reg       <= '0;
      ena_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      miss_reg      <= 4'd0;
      gap_reg       <= 8'd0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
      cmd_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      ser_data_reg  <= 1'b0;
      ser_valid_reg <= 1'b0;
      ser_sof_reg   <= 1'b0;
      ser_eof_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pattern_reg   <= pattern_next;
      len_reg       <= len_next;
      ena_cnt_reg   <= ena_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      miss_reg      <= miss_next;
      gap_reg       <= gap_next;
      err_reg       <= err_next;
      done_reg      <= done_next;
      cmd_ready_reg <= (state_next == S_IDLE);
      busy_reg      <= (state_next != S_IDLE);
      ser_data_reg  <= fwd & sel_data;
      ser_valid_reg <= fwd;
      ser_sof_reg   <= fwd && (bit_cnt_reg == '0);
      ser_eof_reg   <= fwd && (bit_cnt_reg == len_reg - 1'b1);
    end
  end

  // Enables look ahead at the next state so they rise the cycle after acceptance.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ena
    logic ena_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        ena_reg <= 1'b0;
      end else begin
        ena_reg <= (state_next == S_RUN) && (pattern_next == 1'(gi));
      end
    end
    assign ena_vec[gi] = ena_reg;
  end

  assign gen0_ena    = ena_vec[0];
  assign gen1_ena    = ena_vec[1];
  assign cmd_ready   = cmd_ready_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign bit_cnt     = bit_cnt_reg;
  assign err_timeout = err_reg;
  assign ser_data    = ser_data_reg;
  assign ser_valid   = ser_valid_reg;
  assign ser_sof     = ser_sof_reg;
  assign ser_eof     = ser_eof_reg;

endmodule

// File: tb/tb_seq_burst_ctrl.sv
// Directed bench for seq_burst_ctrl with behavioural 1,0,1 and 1,0 generators.
module tb_seq_burst_ctrl;

  localparam int LEN_W      = 16;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_pattern = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             gen0_ena, gen1_ena;
  logic             gen0_data = 1'b0, gen0_valid = 1'b0;
  logic             gen1_data = 1'b0, gen1_valid = 1'b0;
  logic             ser_data, ser_valid, ser_sof, ser_eof;
  logic             busy, done, err_timeout;
  logic [LEN_W-1:0] bit_cnt;

  seq_burst_ctrl #(.LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pattern(cmd_pattern), .cmd_len(cmd_len),
    .gen0_ena(gen0_ena), .gen0_data(gen0_data), .gen0_valid(gen0_valid),
    .gen1_ena(gen1_ena), .gen1_data(gen1_data), .gen1_valid(gen1_valid),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_sof(ser_sof), .ser_eof(ser_eof),
    .busy(busy), .done(done), .bit_cnt(bit_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Generators: registered output one cycle after ena, pattern restarts when ena is low.
  logic [1:0] g0_idx = 2'd0;
  logic       g1_idx = 1'b0;
  logic       g0_stall = 1'b0;
  always @(posedge clk) begin
    if (gen0_ena) begin
      gen0_valid <= !g0_stall;
      gen0_data  <= (g0_idx != 2'd1);
      g0_idx     <= (g0_idx == 2'd2) ? 2'd0 : g0_idx + 2'd1;
    end else begin
      gen0_valid <= 1'b0;
      gen0_data  <= 1'b0;
      g0_idx     <= 2'd0;
    end
    if (gen1_ena) begin
      gen1_valid <= 1'b1;
      gen1_data  <= (g1_idx == 1'b0);
      g1_idx     <= ~g1_idx;
    end else begin
      gen1_valid <= 1'b0;
      gen1_data  <= 1'b0;
      g1_idx     <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-burst observations, cycle numbers relative to the acceptance cycle.
  int r_t, r_ena0_first, r_ena0_n, r_ena1_n, r_bits, r_n, r_sof, r_eof, r_eof_any;
  int r_done, r_done_n, r_bitcnt, r_err_done, r_err_rel1, r_ready;

  task automatic run_burst(input logic pat, input int len, input logic hold,
                           input logic npat, input int nlen);
    int w;
    int rel;
    cmd_pattern = pat;
    cmd_len     = LEN_W'(len);
    cmd_valid   = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      step();
      w++;
    end
    if (!cmd_ready) check_val("accept_wait", 0, 1);
    r_t = cyc;
    r_ena0_first = -1; r_ena0_n = 0; r_ena1_n = 0; r_bits = 0; r_n = 0;
    r_sof = -1; r_eof = -1; r_eof_any = 0; r_done = -1; r_done_n = 0;
    r_bitcnt = -1; r_err_done = -1; r_err_rel1 = -1; r_ready = -1;
    step();
    if (hold) begin
      cmd_pattern = npat;
      cmd_len     = LEN_W'(nlen);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int i = 0; i < 80; i++) begin
      rel = cyc - r_t;
      if (gen0_ena) begin
        if (r_ena0_first < 0) r_ena0_first = rel;
        r_ena0_n++;
      end
      if (gen1_ena) r_ena1_n++;
      if (ser_eof) r_eof_any++;
      if (ser_valid) begin
        r_bits = (r_bits << 1) | int'(ser_data);
        r_n++;
        if (ser_sof) r_sof = rel;
        if (ser_eof) r_eof = rel;
      end
      if (rel == 1) r_err_rel1 = int'(err_timeout);
      if (done) begin
        r_done_n++;
        if (r_done < 0) begin
          r_done     = rel;
          r_bitcnt   = int'(bit_cnt);
          r_err_done = int'(err_timeout);
        end
      end
      if (r_done >= 0 && cmd_ready) begin
        r_ready = rel;
        break;
      end
      step();
    end
    if (r_ready < 0) check_val("burst_end_wait", 0, 1);
    $display("burst pat=%0d len=%0d: ena0=%0d ena1=%0d bits=%0d/%0d sof=%0d eof=%0d done=%0d bit_cnt=%0d err=%0d ready=%0d",
             pat, len, r_ena0_n, r_ena1_n, r_bits, r_n, r_sof, r_eof, r_done, r_bitcnt, r_err_done, r_ready);
  endtask

  int first_done_abs;

  initial begin
    // Reset
    rst = 1'b1;
    step(); step(); step();
    check_val("rst_outs",
              int'({cmd_ready, busy, done, err_timeout, ser_valid, ser_sof, ser_eof, ser_data, gen0_ena, gen1_ena}), 0);
    check_val("rst_bit_cnt", int'(bit_cnt), 0);
    rst = 1'b0;
    step();
    check_val("rst_ready_rise", int'(cmd_ready), 1);
    check_val("rst_busy_idle", int'(busy), 0);
    $display("reset: cmd_ready=%0d busy=%0d", cmd_ready, busy);

    // Pattern 0, len 7
    run_burst(1'b0, 7, 1'b0, 1'b0, 0);
    check_val("p0l7_ena_first", r_ena0_first, 1);
    check_val("p0l7_ena_n", r_ena0_n, 7);
    check_val("p0l7_ena1_n", r_ena1_n, 0);
    check_val("p0l7_bits", r_bits, 91);
    check_val("p0l7_nbits", r_n, 7);
    check_val("p0l7_sof", r_sof, 3);
    check_val("p0l7_eof", r_eof, 9);
    check_val("p0l7_done", r_done, 10);
    check_val("p0l7_done_n", r_done_n, 1);
    check_val("p0l7_bit_cnt", r_bitcnt, 7);
    check_val("p0l7_ready", r_ready, 10 + GAP_CYCLES);

    // Pattern 1, len 6, with the next command (pattern 0, len 1) held valid
    run_burst(1'b1, 6, 1'b1, 1'b0, 1);
    check_val("p1l6_bits", r_bits, 42);
    check_val("p1l6_nbits", r_n, 6);
    check_val("p1l6_ena0_n", r_ena0_n, 0);
    check_val("p1l6_ena1_n", r_ena1_n, 6);
    check_val("p1l6_done", r_done, 9);
    first_done_abs = r_t + r_done;
    check_val("p1l6_held_ready", int'(cmd_ready & cmd_valid), 1);

    // Held command: len 1, pattern 0
    run_burst(1'b0, 1, 1'b0, 1'b0, 0);
    check_val("held_accept_gap", r_t - first_done_abs, GAP_CYCLES);
    check_val("l1_bits", r_bits, 1);
    check_val("l1_nbits", r_n, 1);
    check_val("l1_sof", r_sof, 3);
    check_val("l1_eof", r_eof, 3);
    check_val("l1_done", r_done, 4);

    // len 0
    run_burst(1'b0, 0, 1'b0, 1'b0, 0);
    check_val("l0_ena", r_ena0_n + r_ena1_n, 0);
    check_val("l0_nbits", r_n, 0);
    check_val("l0_done", r_done, 1);
    check_val("l0_bit_cnt", r_bitcnt, 0);
    check_val("l0_ready", r_ready, 1 + GAP_CYCLES);

    // Timeout with gen0 never valid
    g0_stall = 1'b1;
    run_burst(1'b0, 5, 1'b0, 1'b0, 0);
    g0_stall = 1'b0;
    check_val("to_err", r_err_done, 1);
    check_val("to_done", r_done, 2 + TIMEOUT);
    check_val("to_done_n", r_done_n, 1);
    check_val("to_eof_any", r_eof_any, 0);
    check_val("to_nbits", r_n, 0);
    check_val("to_bit_cnt", r_bitcnt, 0);
    check_val("to_err_sticky", int'(err_timeout), 1);

    // Next command clears err_timeout
    run_burst(1'b1, 2, 1'b0, 1'b0, 0);
    check_val("clr_err", r_err_rel1, 0);
    check_val("clr_bits", r_bits, 2);
    check_val("clr_nbits", r_n, 2);

    // Reset in the third RUN cycle of a len 10 burst
    cmd_pattern = 1'b0;
    cmd_len     = LEN_W'(10);
    cmd_valid   = 1'b1;
    for (int w = 0; w < 100 && !cmd_ready; w++) step();
    check_val("mid_accept_ready", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    check_val("mid_ena_run", int'(gen0_ena), 1);
    step(); step();
    rst = 1'b1;
    step();
    check_val("mid_rst_outs",
              int'({cmd_ready, busy, done, ser_valid, ser_sof, ser_eof, ser_data, gen0_ena, gen1_ena}), 0);
    $display("mid-burst reset: busy=%0d gen0_ena=%0d ser_valid=%0d", busy, gen0_ena, ser_valid);
    rst = 1'b0;
    step();
    check_val("mid_ready_back", int'(cmd_ready), 1);
    run_burst(1'b0, 3, 1'b0, 1'b0, 0);
    check_val("post_rst_bits", r_bits, 5);
    check_val("post_rst_nbits", r_n, 3);
    check_val("post_rst_eof", r_eof, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
